mvu_requant_axi: RTL and testbench



---
 rtl/mvu_requant_axi.sv | 124 ++++++++++++
 tb/tb_mvu_requant_axi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mvu_requant_axi.sv
// Per-channel bias add, arithmetic right shift and saturation of PE-lane accumulator beats.
// 2-cycle latency, 1 beat/cycle; stalls propagate back when both stages are full. Define MVU_REQUANT_ROUND_EN for round-half-up.
module mvu_requant_axi #(
  parameter int MH            = 64,
  parameter int PE            = 4,
  parameter int ACCU_WIDTH    = 16,
  parameter int BIAS_WIDTH    = 16,
  parameter int SHIFT         = 4,
  parameter int OUT_WIDTH     = 8,
  parameter int SIGNED_OUTPUT = 1,
  localparam int IW = (PE*ACCU_WIDTH+7)/8*8,
  localparam int OW = (PE*OUT_WIDTH+7)/8*8,
  localparam int AW = (MH > 1) ? $clog2(MH) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [IW-1:0]         s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [OW-1:0]         m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [BIAS_WIDTH-1:0] cfg_data
);

  localparam int FOLDS = MH / PE;
  localparam int FW    = (FOLDS > 1) ? $clog2(FOLDS) : 1;
  localparam int SW    = ACCU_WIDTH + 2;
  localparam logic signed [SW-1:0] HI = (SIGNED_OUTPUT != 0) ? SW'((2**(OUT_WIDTH-1))-1) : SW'((2**OUT_WIDTH)-1);
  localparam logic signed [SW-1:0] LO = (SIGNED_OUTPUT != 0) ? -SW'(2**(OUT_WIDTH-1)) : '0;
`ifdef MVU_REQUANT_ROUND_EN
  localparam logic signed [SW-1:0] RND = (SHIFT > 0) ? SW'((2**SHIFT)/2) : '0;
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic [BIAS_WIDTH-1:0]  r_bias [MH];
  logic [FW-1:0]          r_fold;
  logic                   r_s1_vld;
  logic signed [SW-1:0]   r_s1_sum [PE];
  logic                   r_s2_vld;
  logic [OW-1:0]          r_s2_dat;

  logic                   w_en;
  logic                   w_s_rdy;
  logic                   w_s_hs;
  logic signed [SW-1:0]   w_sum [PE];
  logic signed [SW-1:0]   w_sh  [PE];
  logic [OW-1:0]          w_out;

  assign w_en          = !r_s2_vld || m_axis_tready;
  assign w_s_rdy       = w_en || !r_s1_vld;
  assign w_s_hs        = s_axis_tvalid && w_s_rdy;
  assign s_axis_tready = w_s_rdy;
  assign m_axis_tvalid = r_s2_vld;
  assign m_axis_tdata  = r_s2_dat;

  // Bias RAM is deliberately unreset; a write lands after this cycle's read, so a same-cycle beat sees the old value.
  always_ff @(posedge ap_clk) begin
    if (cfg_we && (int'(cfg_addr) < MH)) begin
      r_bias[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    for (int p = 0; p < PE; p++) begin
      w_sum[p] = SW'($signed(s_axis_tdata[p*ACCU_WIDTH +: ACCU_WIDTH]))
               + SW'($signed(r_bias[AW'(int'(r_fold)*PE + p)]));
    end
  end

  always_comb begin
    w_out = '0;
    for (int p = 0; p < PE; p++) begin
      w_sh[p] = (r_s1_sum[p] + RND) >>> SHIFT;
      if (w_sh[p] > HI) begin
        w_out[p*OUT_WIDTH +: OUT_WIDTH] = HI[OUT_WIDTH-1:0];
      end else if (w_sh[p] < LO) begin
        w_out[p*OUT_WIDTH +: OUT_WIDTH] = LO[OUT_WIDTH-1:0];
      end else begin
        w_out[p*OUT_WIDTH +: OUT_WIDTH] = w_sh[p][OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_fold <= '0;
    end else if (w_s_hs) begin
      r_fold <= (int'(r_fold) == FOLDS-1) ? '0 : r_fold + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_vld <= 1'b0;
      for (int p = 0; p < PE; p++) begin
        r_s1_sum[p] <= '0;
      end
    end else if (w_s_rdy) begin
      r_s1_vld <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        for (int p = 0; p < PE; p++) begin
          r_s1_sum[p] <= w_sum[p];
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
    end else if (w_en) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_dat <= w_out;
      end
    end
  end

endmodule

// File: tb/tb_mvu_requant_axi.sv
// Directed + randomized bench for mvu_requant_axi (MH=8, PE=2, SHIFT=4, 8-bit signed out).
// Reference model works on plain integers per channel with a queue of expected output words.
module tb_mvu_requant_axi;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;

  int checks = 0;
  int failures = 0;
  int bias_m [8];
  int fold_m = 0;
  int n_in = 0;
  int n_out = 0;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];

  mvu_requant_axi #(.MH(8), .PE(2), .ACCU_WIDTH(16), .BIAS_WIDTH(16), .SHIFT(4),
                    .OUT_WIDTH(8), .SIGNED_OUTPUT(1)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data));

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Floor division by 16 and clamping to int8, done on plain integers.
  function automatic logic [7:0] ref_lane(input logic [15:0] acc, input int b);
    int s;
    logic [31:0] r;
    s = int'($signed(acc)) + b;
`ifdef MVU_REQUANT_ROUND_EN
    s = s + 8;
`endif
    s = (s >= 0) ? s / 16 : -((-s + 15) / 16);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    r = s;
    return r[7:0];
  endfunction

  task automatic step();
    @(negedge ap_clk);
    if (s_axis_tvalid && s_axis_tready) begin
      exp_q.push_back({ref_lane(s_axis_tdata[31:16], bias_m[fold_m*2+1]),
                       ref_lane(s_axis_tdata[15:0],  bias_m[fold_m*2])});
      fold_m = (fold_m + 1) % 4;
      n_in++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      n_out++;
      got_q.push_back(m_axis_tdata);
      check("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("stream_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
    end
    if (cfg_we) bias_m[cfg_addr] = int'($signed(cfg_data));
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wr_bias(input int c, input int v);
    cfg_we = 1'b1; cfg_addr = 3'(c); cfg_data = 16'(v);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    #2 ap_rst_n = 1'b0;
    #1 check("rst_async_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    exp_q.delete(); got_q.delete();
    fold_m = 0;
  endtask

  initial begin
    int k;
    ap_rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset_tdata",  32'(m_axis_tdata),  32'd0);
    ap_rst_n = 1'b1;

    // Basic beat with zero bias and latency check
    for (int c = 0; c < 8; c++) wr_bias(c, 0);
    s_axis_tdata = {16'hFF00, 16'h0100}; s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    check("lat_cycle1_tvalid", 32'(m_axis_tvalid), 32'd0);
    step();
    check("lat_cycle2_tvalid", 32'(m_axis_tvalid), 32'd1);
    step();
    check("basic_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("basic_value", 32'(got_q[0]), 32'h0000F010);

    // Saturation both directions
    wr_bias(0, 16'h0100); wr_bias(1, 16'hFFFF);
    do_reset();
    s_axis_tdata = {16'h8000, 16'h7FF0}; s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    repeat (3) step();
    check("sat_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("sat_value", 32'(got_q[0]), 32'h0000807F);

    // Fold wrap with bias[c] = 16*c
    for (int c = 0; c < 8; c++) wr_bias(c, 16*c);
    do_reset();
    s_axis_tdata = '0; s_axis_tvalid = 1'b1;
    repeat (5) step();
    s_axis_tvalid = 1'b0;
    repeat (3) step();
    check("fold_count", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) begin
      check("fold0", 32'(got_q[0]), 32'h0100);
      check("fold1", 32'(got_q[1]), 32'h0302);
      check("fold2", 32'(got_q[2]), 32'h0504);
      check("fold3", 32'(got_q[3]), 32'h0706);
      check("fold_wrap", 32'(got_q[4]), 32'h0100);
    end

    // Rounding vs truncation
    wr_bias(0, 0); wr_bias(1, 0);
    do_reset();
    s_axis_tdata = {16'hFFF8, 16'h0008}; s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    repeat (3) step();
    check("round_count", 32'(got_q.size()), 32'd1);
`ifdef MVU_REQUANT_ROUND_EN
    if (got_q.size() > 0) check("round_value", 32'(got_q[0]), 32'h0001);
`else
    if (got_q.size() > 0) check("trunc_value", 32'(got_q[0]), 32'hFF00);
`endif

    // Backpressure: full stall, then full rate, then random ready with bias updates
    for (int c = 0; c < 8; c++) wr_bias(c, int'($urandom_range(0, 65535)));
    do_reset();
    n_in = 0; n_out = 0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = $urandom;
    for (int i = 0; i < 10; i++) begin
      k = n_in;
      step();
      if (n_in != k) s_axis_tdata = $urandom;
      if (i >= 2) check("stall_s_tready", 32'(s_axis_tready), 32'd0);
    end
    check("stall_accepted", 32'(n_in), 32'd2);
    m_axis_tready = 1'b1;
    step();
    s_axis_tdata = $urandom;
    k = n_in;
    for (int i = 0; i < 20; i++) begin
      step();
      s_axis_tdata = $urandom;
    end
    check("full_rate", 32'(n_in - k), 32'd20);
    for (int i = 0; i < 300; i++) begin
      m_axis_tready = ($urandom_range(0, 1) == 1);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = 16'($urandom);
      case ($urandom_range(0, 5))
        0: s_axis_tdata = 32'h7FFF_8000;
        1: s_axis_tdata = 32'h8000_7FFF;
        default: s_axis_tdata = $urandom;
      endcase
      step();
    end
    cfg_we = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    repeat (5) step();
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_in_eq_out", 32'(n_out), 32'(n_in));

    // Reset mid-stream with beats in flight
    for (int c = 0; c < 8; c++) wr_bias(c, 16*(c+1));
    do_reset();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0000_0000;
    repeat (3) step();
    s_axis_tvalid = 1'b0;
    check("midrst_inflight", 32'(m_axis_tvalid), 32'd1);
    do_reset();
    check("midrst_tvalid_after", 32'(m_axis_tvalid), 32'd0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0000_0000;
    step();
    s_axis_tvalid = 1'b0;
    repeat (6) step();
    check("midrst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("midrst_fold0", 32'(got_q[0]), 32'h0201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
